alu_exec_seq: RTL

- Multi-cycle ALU datapath that consumes the 4-bit ALU control code produced by the ALU control decoder (func3/func7/alu_op -> code).
- Executes the selected operation on two WIDTH-bit operands and returns the result with a zero flag.
- Single-cycle logic ops. Iterative 1-bit-per-cycle shifts. Optional iterative multiply.
- Valid/ready handshake on both the input and output sides. Sits between the register-read stage and writeback.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_comb_unit.sv | 33 +++
 rtl/alu_exec_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and execution FSM state encodings
// Shared with the ALU control decoder (func3/func7/alu_op -> 4-bit code).
// No ports.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // MUL is only ever entered when ALU_EXEC_MUL_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_comb_unit.sv
// rtl/alu_comb_unit.sv - single-cycle ALU ops (AND/OR/ADD/SUB/SLT/NOR)
// Ports:
//   ctrl_i  : 4-bit ALU control code
//   a_i/b_i : operands
//   y_o     : result (0 when the code is not a single-cycle op)
//   hit_o   : high when ctrl_i selects one of the ops handled here
module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             hit_o
);

  always_comb begin
    y_o   = '0;
    hit_o = 1'b1;
    case (ctrl_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_SLT: y_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_NOR: y_o = ~(a_i | b_i);
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - multi-cycle ALU: 1-cycle logic, iterative shifts, optional multiply
// Optional feature macro: ALU_EXEC_MUL_EN (shift-add multiply on code 1000).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operation handshake (in_ready only in IDLE)
//   alu_ctrl, op_a, op_b: control code and operands, sampled at acceptance
//   out_valid/out_ready : result handshake
//   result, zero        : registered result and result==0 flag
//   illegal             : unsupported control code flag
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       sop_q, sop_d;

  logic [WIDTH-1:0] comb_y;
  logic             comb_hit;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shifted;

`ifdef ALU_EXEC_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nx;

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
    .ctrl_i (alu_ctrl),
    .a_i    (op_a),
    .b_i    (op_b),
    .y_o    (comb_y),
    .hit_o  (comb_hit)
  );

  assign shamt = op_b[SHW-1:0];

  // One-bit step of the latched shift kind.
  always_comb begin
    case (sop_q)
      ALU_SLL: shifted = {work_q[WIDTH-2:0], 1'b0};
      ALU_SRA: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = {1'b0, work_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      sop_q     <= '0;
`ifdef ALU_EXEC_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      sop_q     <= sop_d;
`ifdef ALU_EXEC_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    sop_d     = sop_q;
`ifdef ALU_EXEC_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          illegal_d = 1'b0;
          state_d   = DONE;
          case (alu_ctrl)
            ALU_SLL, ALU_SRL, ALU_SRA: begin
              sop_d = alu_ctrl;
              if (shamt == '0) begin
                result_d = op_a;
              end else begin
                work_d  = op_a;
                cnt_d   = shamt;
                state_d = SHIFT;
              end
            end
`ifdef ALU_EXEC_MUL_EN
            ALU_MUL: begin
              mcand_d  = op_a;
              mplier_d = op_b;
              acc_d    = '0;
              state_d  = MUL;
            end
`endif
            default: begin
              if (comb_hit) begin
                result_d = comb_y;
              end else begin
                result_d  = '0;
                illegal_d = 1'b1;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        // Counter holds the steps still to do including this one.
        if (cnt_q == SHW'(1)) begin
          result_d = shifted;
          state_d  = DONE;
        end
      end
`ifdef ALU_EXEC_MUL_EN
      MUL: begin
        acc_d    = acc_nx;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        // Stop once no set multiplier bits remain above the current one.
        if (mplier_q[WIDTH-1:1] == '0) begin
          result_d = acc_nx;
          state_d  = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign zero      = (state_q == DONE) && (result_q == '0);

endmodule
